keypad_debounce_fifo: RTL and testbench

Upstream front end for the two-digit hex display path. Scans the 4x4 keypad one column at a time, synchronizes and debounces the row inputs, and turns each clean press into a 4-bit hex key code. Codes go into a small FIFO with a valid/ready interface. The consumer is the digit-shift/display stage, which pops one code per accepted handshake. Unlike the existing freeze-on-held scanner, this block rejects bounce and glitches, and it never loses a press while the consumer stalls, unless the FIFO overflows.

---
 rtl/keypad_debounce_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_keypad_debounce_fifo.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce_fifo.sv
// 4x4 keypad scanner with row synchronizer, press/release debounce and a
// small valid/ready FIFO of hex key codes feeding the display shift stage.
module keypad_debounce_fifo #(
   parameter int SCANBITS = 3,
   parameter int DEBOUNCE = 4,
   parameter int DEPTH    = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [3:0]              rows,
   output wire  [3:0]              cols,
   output logic [3:0]              key_code,
   output logic                    key_valid,
   input  logic                    key_ready,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic                    overflow
);

   // state       | meaning
   // SCAN        | walking columns, waiting for any row to go high
   // DEB_PRESS   | counting agreeing ticks of the latched row before accepting
   // HELD        | press accepted and pushed; column frozen until release
   // DEB_RELEASE | counting agreeing low ticks before resuming the scan
   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [3:0]      DEB      = 4'(DEBOUNCE);
   localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

   logic [3:0]          sync1;
   logic [3:0]          srows;
   logic [SCANBITS-1:0] tick_cnt;
   logic                tick;
   state_t              state;
   logic [1:0]          col;
   logic [3:0]          row_sel;
   logic [3:0]          cnt;
   logic [3:0]          pri_row;
   logic                row_hit;
   logic                push;
   logic [3:0]          push_code;
   logic                pop;
   logic                full;
   logic                wr_en;
   logic [AW-1:0]       wptr;
   logic [AW-1:0]       rptr;
   logic [3:0]          mem [DEPTH];

   function automatic logic [3:0] top_row(input logic [3:0] r);
      logic [3:0] oh;
      oh = 4'b0000;
      if (r[3])      oh = 4'b1000;
      else if (r[2]) oh = 4'b0100;
      else if (r[1]) oh = 4'b0010;
      else if (r[0]) oh = 4'b0001;
      return oh;
   endfunction

   // Row index counts from the top of the pad (rows[3] is index 0).
   function automatic logic [3:0] key_lookup(input logic [1:0] c, input logic [3:0] r1h);
      logic [1:0] ri;
      logic [3:0] k;
      ri = r1h[3] ? 2'd0 : r1h[2] ? 2'd1 : r1h[1] ? 2'd2 : 2'd3;
      case ({c, ri})
         4'b00_00: k = 4'h1;
         4'b00_01: k = 4'h4;
         4'b00_10: k = 4'h7;
         4'b00_11: k = 4'hE;
         4'b01_00: k = 4'h2;
         4'b01_01: k = 4'h5;
         4'b01_10: k = 4'h8;
         4'b01_11: k = 4'h0;
         4'b10_00: k = 4'h3;
         4'b10_01: k = 4'h6;
         4'b10_10: k = 4'h9;
         4'b10_11: k = 4'hF;
         4'b11_00: k = 4'hA;
         4'b11_01: k = 4'hB;
         4'b11_10: k = 4'hC;
         default:  k = 4'hD;
      endcase
      return k;
   endfunction

   for (genvar i = 0; i < 4; i++) begin : g_col
      assign cols[3-i] = (col == 2'(i)) ? 1'b1 : 1'bz;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= 4'b0000;
         srows    <= 4'b0000;
         tick_cnt <= '0;
      end else begin
         sync1    <= rows;
         srows    <= sync1;
         tick_cnt <= tick_cnt + SCANBITS'(1);
      end
   end

   assign tick    = &tick_cnt;
   assign pri_row = top_row(srows);
   assign row_hit = |(srows & row_sel);

   // The push lands on the qualifying tick edge, so it is decoded here rather
   // than registered inside the FSM.
   always_comb begin
      push = 1'b0;
      if (tick) begin
         if (state == SCAN && srows != 4'b0000 && DEBOUNCE == 1)
            push = 1'b1;
         else if (state == DEB_PRESS && row_hit && (cnt + 4'd1 == DEB))
            push = 1'b1;
      end
   end

   assign push_code = key_lookup(col, (state == SCAN) ? pri_row : row_sel);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= SCAN;
         col     <= 2'd0;
         row_sel <= 4'b0000;
         cnt     <= 4'd0;
      end else if (tick) begin
         case (state)
            SCAN: begin
               if (srows == 4'b0000) begin
                  col <= col + 2'd1;
               end else begin
                  row_sel <= pri_row;
                  if (DEBOUNCE == 1) begin
                     state <= HELD;
                     cnt   <= 4'd0;
                  end else begin
                     state <= DEB_PRESS;
                     cnt   <= 4'd1;
                  end
               end
            end
            DEB_PRESS: begin
               if (row_hit) begin
                  if (cnt + 4'd1 == DEB) begin
                     state <= HELD;
                     cnt   <= 4'd0;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end else begin
                  state   <= SCAN;
                  row_sel <= 4'b0000;
                  cnt     <= 4'd0;
               end
            end
            HELD: begin
               if (!row_hit) begin
                  if (DEBOUNCE == 1) begin
                     state   <= SCAN;
                     col     <= col + 2'd1;
                     row_sel <= 4'b0000;
                     cnt     <= 4'd0;
                  end else begin
                     state <= DEB_RELEASE;
                     cnt   <= 4'd1;
                  end
               end
            end
            DEB_RELEASE: begin
               if (!row_hit) begin
                  if (cnt + 4'd1 == DEB) begin
                     state   <= SCAN;
                     col     <= col + 2'd1;
                     row_sel <= 4'b0000;
                     cnt     <= 4'd0;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end else begin
                  state <= HELD;
                  cnt   <= 4'd0;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

   assign key_valid = (fifo_count != '0);
   assign full      = (fifo_count == FULL_CNT);
   assign pop       = key_valid & key_ready;
   // A full FIFO still takes the push when the head leaves in the same cycle.
   assign wr_en     = push & (~full | pop);
   assign key_code  = key_valid ? mem[rptr] : 4'h0;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wptr] <= push_code;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (push & full & ~pop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_keypad_debounce_fifo.sv
// Directed bench for keypad_debounce_fifo with SCANBITS=2, DEBOUNCE=3, DEPTH=4.
// Inputs change 1ns after an edge; a tick edge is every 4th edge after reset release.
module tb_keypad_debounce_fifo;

   logic       clk;
   logic       reset_n;
   logic [3:0] rows;
   wire  [3:0] cols;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic [2:0] fifo_count;
   logic       overflow;

   int checks;
   int errors;
   int cyc;

   keypad_debounce_fifo #(.SCANBITS(2), .DEBOUNCE(3), .DEPTH(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rows       (rows),
      .cols       (cols),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   function automatic bit col_on(input logic [3:0] cv, input int c);
      bit ok;
      ok = (cv[3-c] === 1'b1);
      for (int j = 0; j < 4; j++)
         if (j != 3 - c && cv[j] === 1'b1) ok = 1'b0;
      return ok;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic next_tick();
      step();
      while (cyc % 4 != 0) step();
   endtask

   task automatic wait_col(input int c);
      int n;
      n = 0;
      while (!col_on(cols, c) && n < 8) begin
         next_tick();
         n++;
      end
      checks++;
      if (!col_on(cols, c)) begin
         errors++;
         $display("FAIL wait_col: cols=%b never selected column %0d", cols, c);
      end
   endtask

   task automatic press_key(input int c, input logic [3:0] r);
      wait_col(c);
      rows = r;
      repeat (3) next_tick();
      rows = 4'b0000;
      repeat (3) next_tick();
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      rows      = 4'b0000;
      key_ready = 1'b0;
      #1;
      checks++;
      if (!col_on(cols, 0) || key_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 || key_code !== 4'h0) begin
         errors++;
         $display("FAIL reset_values: cols=%b valid=%b count=%0d ovf=%b code=%h, want cols=1zzz valid=0 count=0 ovf=0 code=0",
                  cols, key_valid, fifo_count, overflow, key_code);
      end
      step();
      step();
      reset_n = 1'b1;
      cyc     = 0;
      repeat (3) step();
      checks++;
      if (!col_on(cols, 0)) begin
         errors++;
         $display("FAIL first_tick_early: cols=%b at cycle 3, want 1zzz", cols);
      end
      step();
      checks++;
      if (!col_on(cols, 1)) begin
         errors++;
         $display("FAIL first_tick: cols=%b after first tick, want z1zz", cols);
      end
   endtask

   task automatic test_clean_press();
      wait_col(1);
      rows = 4'b0100;
      next_tick();
      next_tick();
      checks++;
      if (key_valid !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL press_early: valid=%b count=%0d after 2 ticks, want 0/0", key_valid, fifo_count);
      end
      next_tick();
      checks++;
      if (key_valid !== 1'b1 || key_code !== 4'h5 || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL press_push: valid=%b code=%h count=%0d, want 1/5/1", key_valid, key_code, fifo_count);
      end
      checks++;
      if (!col_on(cols, 1)) begin
         errors++;
         $display("FAIL press_col_hold: cols=%b, want z1zz", cols);
      end
      next_tick();
      next_tick();
      checks++;
      if (fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL press_no_repeat: count=%0d after 5 held ticks, want 1", fifo_count);
      end
      rows = 4'b0000;
      repeat (3) next_tick();
      checks++;
      if (!col_on(cols, 2)) begin
         errors++;
         $display("FAIL press_release_adv: cols=%b, want zz1z", cols);
      end
      key_ready = 1'b1;
      step();
      key_ready = 1'b0;
      checks++;
      if (key_valid !== 1'b0 || fifo_count !== 3'd0 || key_code !== 4'h0) begin
         errors++;
         $display("FAIL press_pop: valid=%b count=%0d code=%h, want 0/0/0", key_valid, fifo_count, key_code);
      end
   endtask

   task automatic test_bounce();
      wait_col(2);
      rows = 4'b0010;
      next_tick();
      next_tick();
      rows = 4'b0000;
      next_tick();
      checks++;
      if (fifo_count !== 3'd0 || !col_on(cols, 2)) begin
         errors++;
         $display("FAIL bounce_reject: count=%0d cols=%b, want 0 and zz1z", fifo_count, cols);
      end
      rows = 4'b0010;
      next_tick();
      next_tick();
      checks++;
      if (fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL bounce_early: count=%0d after 2 steady ticks, want 0", fifo_count);
      end
      next_tick();
      checks++;
      if (fifo_count !== 3'd1 || key_code !== 4'h9 || key_valid !== 1'b1) begin
         errors++;
         $display("FAIL bounce_push: count=%0d code=%h valid=%b, want 1/9/1", fifo_count, key_code, key_valid);
      end
      rows = 4'b0000;
      repeat (3) next_tick();
      key_ready = 1'b1;
      step();
      key_ready = 1'b0;
   endtask

   task automatic test_release();
      wait_col(0);
      rows = 4'b0001;
      repeat (3) next_tick();
      checks++;
      if (fifo_count !== 3'd1 || key_code !== 4'hE) begin
         errors++;
         $display("FAIL release_push: count=%0d code=%h, want 1/E", fifo_count, key_code);
      end
      rows = 4'b0000;
      next_tick();
      next_tick();
      rows = 4'b0001;
      next_tick();
      checks++;
      if (!col_on(cols, 0)) begin
         errors++;
         $display("FAIL release_bounce_col: cols=%b, want 1zzz", cols);
      end
      rows = 4'b0000;
      next_tick();
      next_tick();
      checks++;
      if (!col_on(cols, 0)) begin
         errors++;
         $display("FAIL release_early: cols=%b after 2 low ticks, want 1zzz", cols);
      end
      next_tick();
      checks++;
      if (!col_on(cols, 1) || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL release_done: cols=%b count=%0d, want z1zz and 1", cols, fifo_count);
      end
      key_ready = 1'b1;
      step();
      key_ready = 1'b0;
   endtask

   task automatic test_reset_mid_hold();
      wait_col(1);
      rows = 4'b1000;
      repeat (4) next_tick();
      checks++;
      if (fifo_count !== 3'd1 || key_code !== 4'h2) begin
         errors++;
         $display("FAIL hold_setup: count=%0d code=%h, want 1/2", fifo_count, key_code);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (!col_on(cols, 0) || key_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 || key_code !== 4'h0) begin
         errors++;
         $display("FAIL hold_reset: cols=%b valid=%b count=%0d ovf=%b code=%h, want 1zzz/0/0/0/0",
                  cols, key_valid, fifo_count, overflow, key_code);
      end
      rows = 4'b0000;
      step();
      step();
      reset_n = 1'b1;
      cyc     = 0;
   endtask

   task automatic test_overflow();
      logic [3:0] exp_codes [4];
      exp_codes[0] = 4'h1;
      exp_codes[1] = 4'h2;
      exp_codes[2] = 4'h3;
      exp_codes[3] = 4'hA;
      press_key(0, 4'b1000);
      press_key(1, 4'b1000);
      press_key(2, 4'b1000);
      press_key(3, 4'b1000);
      checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_full: count=%0d ovf=%b, want 4/0", fifo_count, overflow);
      end
      press_key(3, 4'b0100);
      checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drop: count=%0d ovf=%b, want 4/1", fifo_count, overflow);
      end
      key_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (key_valid !== 1'b1 || key_code !== exp_codes[i]) begin
            errors++;
            $display("FAIL ovf_order[%0d]: valid=%b code=%h, want 1/%h", i, key_valid, key_code, exp_codes[i]);
         end
         step();
      end
      key_ready = 1'b0;
      checks++;
      if (key_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drained: valid=%b count=%0d ovf=%b, want 0/0/1", key_valid, fifo_count, overflow);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_codes [4];
      exp_codes[0] = 4'h2;
      exp_codes[1] = 4'h3;
      exp_codes[2] = 4'hA;
      exp_codes[3] = 4'hB;
      press_key(0, 4'b1000);
      press_key(1, 4'b1000);
      press_key(2, 4'b1000);
      press_key(3, 4'b1000);
      wait_col(3);
      rows = 4'b0100;
      next_tick();
      next_tick();
      while (cyc % 4 != 3) step();
      key_ready = 1'b1;
      step();
      key_ready = 1'b0;
      checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b0 || key_code !== 4'h2) begin
         errors++;
         $display("FAIL simul_push_pop: count=%0d ovf=%b head=%h, want 4/0/2", fifo_count, overflow, key_code);
      end
      rows = 4'b0000;
      repeat (3) next_tick();
      key_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (key_valid !== 1'b1 || key_code !== exp_codes[i]) begin
            errors++;
            $display("FAIL simul_order[%0d]: valid=%b code=%h, want 1/%h", i, key_valid, key_code, exp_codes[i]);
         end
         step();
      end
      key_ready = 1'b0;
      checks++;
      if (key_valid !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL simul_drained: valid=%b count=%0d, want 0/0", key_valid, fifo_count);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      reset_n   = 1'b0;
      rows      = 4'b0000;
      key_ready = 1'b0;
      #12;
      test_reset();
      test_clean_press();
      test_bounce();
      test_release();
      test_reset_mid_hold();
      test_overflow();
      test_reset();
      test_simultaneous();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
